// File: rtl/trigger_ctrl_pkg.sv
// trigger_ctrl_pkg
// Shared definitions for trigger_arm_ctrl and its edge detector.
//   - State encodings and the state_t enum used by the shot FSM
//   - Host configuration address map for the three trigger levels
//   - Reset value of the captured pulse delay
package trigger_ctrl_pkg;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_FLUSH   = 3'd1;
  localparam logic [2:0] ENC_ARMED   = 3'd2;
  localparam logic [2:0] ENC_WAIT_T1 = 3'd3;
  localparam logic [2:0] ENC_DELAY   = 3'd4;
  localparam logic [2:0] ENC_DONE    = 3'd5;
  localparam logic [2:0] ENC_TIMEOUT = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_FLUSH   = ENC_FLUSH,
    ST_ARMED   = ENC_ARMED,
    ST_WAIT_T1 = ENC_WAIT_T1,
    ST_DELAY   = ENC_DELAY,
    ST_DONE    = ENC_DONE,
    ST_TIMEOUT = ENC_TIMEOUT
  } state_t;

  localparam logic [1:0] ADDR_LVL_A = 2'd1;
  localparam logic [1:0] ADDR_LVL_B = 2'd2;
  localparam logic [1:0] ADDR_LVL_C = 2'd3;

  // "No shot completed yet" marker for delay_out.
  localparam logic [15:0] DELAY_OUT_RST = 16'hFFFF;

endpackage

// File: rtl/trig_edge_det.sv
// trig_edge_det
// One-cycle history register with combinational rise/fall decode.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (history clears to 0)
//   sig      : level input from trigger_gen
//   rise     : sig is 1 now and was 0 last cycle
//   fall     : sig is 0 now and was 1 last cycle
module trig_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 1'b0;
    end else begin
      hist <= sig;
    end
  end

  assign rise = sig & ~hist;
  assign fall = ~sig & hist;

endmodule

// File: rtl/trigger_arm_ctrl.sv
// trigger_arm_ctrl
// Shot sequencer and level-register owner for trigger_gen.
// Ports:
//   clk, rst        : 125 MHz ADC clock, asynchronous active-high reset
//   cfg_wrt/addr/data : host level writes (1=a, 2=b, 3=c), accepted only when idle
//   timeout_lim     : shot timeout in cycles, 0 disables
//   arm, abort      : single-cycle host commands
//   trigger0/1      : progress inputs from trigger_gen
//   pulse_delay     : measured delay from trigger_gen, captured on trigger1 rise
//   trig_enable     : enable to trigger_gen
//   trig_level_arr  : {level_c, level_b, level_a}
//   busy            : FSM not in IDLE
//   done            : one-cycle shot-complete pulse
//   timed_out       : sticky timeout flag, cleared by an accepted arm
//   delay_out       : pulse_delay of the last completed shot
//   shot_cnt        : completed shot count (wraps)
//   state_dbg       : current FSM state encoding for observation
//
// Handshake: arm/abort/cfg_wrt are single-cycle strobes sampled on the clock
// edge; there is no ready back-pressure, a command is either acted on in the
// cycle it is sampled or dropped (arm while busy, cfg_wrt while busy).
module trigger_arm_ctrl
  import trigger_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 4,
  parameter int TIMEOUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wrt,
  input  logic [1:0]               cfg_addr,
  input  logic [15:0]              cfg_data,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_lim,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trigger0,
  input  logic                     trigger1,
  input  logic [15:0]              pulse_delay,
  output logic                     trig_enable,
  output logic [47:0]              trig_level_arr,
  output logic                     busy,
  output logic                     done,
  output logic                     timed_out,
  output logic [15:0]              delay_out,
  output logic [15:0]              shot_cnt,
  output logic [2:0]               state_dbg
);

  // Width holds 0..FLUSH_CYCLES-1; +1 keeps FLUSH_CYCLES=1 at one bit.
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

  state_t                   state;
  logic [FC_W-1:0]          flush_cnt;
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
  logic [TIMEOUT_WIDTH-1:0] to_inc;
  logic                     to_hit;
  logic [15:0]              level_a, level_b, level_c;
  logic                     t0_rise, t1_rise, t1_fall;
  logic                     unused_t0_fall;

  trig_edge_det u_edge_t0 (
    .clk  (clk),
    .rst  (rst),
    .sig  (trigger0),
    .rise (t0_rise),
    .fall (unused_t0_fall)
  );

  trig_edge_det u_edge_t1 (
    .clk  (clk),
    .rst  (rst),
    .sig  (trigger1),
    .rise (t1_rise),
    .fall (t1_fall)
  );

  // The count the timer will hold after this edge; the timeout fires on the
  // edge where that count reaches the limit.
  assign to_inc = to_cnt + 1'b1;
  assign to_hit = (timeout_lim != '0) && (to_inc == timeout_lim);

  assign busy           = (state != ST_IDLE);
  assign state_dbg      = state;
  assign trig_level_arr = {level_c, level_b, level_a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      flush_cnt   <= '0;
      to_cnt      <= '0;
      level_a     <= '0;
      level_b     <= '0;
      level_c     <= '0;
      trig_enable <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      delay_out   <= DELAY_OUT_RST;
      shot_cnt    <= '0;
    end else begin
      done <= 1'b0;

      // Writes in the same cycle as an accepted arm still land, so the shot
      // runs with the new level.
      if (cfg_wrt && (state == ST_IDLE)) begin
        case (cfg_addr)
          ADDR_LVL_A: level_a <= cfg_data;
          ADDR_LVL_B: level_b <= cfg_data;
          ADDR_LVL_C: level_c <= cfg_data;
          default:    ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          trig_enable <= 1'b0;
          if (arm && !abort) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            to_cnt    <= '0;
            timed_out <= 1'b0;
          end
        end

        ST_FLUSH: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (flush_cnt == FLUSH_LAST) begin
            state       <= ST_ARMED;
            trig_enable <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        ST_ARMED, ST_WAIT_T1, ST_DELAY: begin
          to_cnt <= to_inc;
          if (abort) begin
            state       <= ST_IDLE;
            trig_enable <= 1'b0;
          end else if ((state == ST_ARMED) && t0_rise && t1_rise) begin
            state     <= ST_DELAY;
            delay_out <= pulse_delay;
          end else if ((state == ST_ARMED) && t0_rise) begin
            state <= ST_WAIT_T1;
          end else if ((state == ST_WAIT_T1) && t1_rise) begin
            state     <= ST_DELAY;
            delay_out <= pulse_delay;
          end else if ((state == ST_DELAY) && t1_fall) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            shot_cnt    <= shot_cnt + 1'b1;
            trig_enable <= 1'b0;
          end else if (to_hit) begin
            state       <= ST_TIMEOUT;
            timed_out   <= 1'b1;
            trig_enable <= 1'b0;
          end
        end

        ST_DONE, ST_TIMEOUT: begin
          state       <= ST_IDLE;
          trig_enable <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          trig_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_arm_ctrl.sv
module tb_trigger_arm_ctrl;

  localparam int FC = 4;
  localparam int TW = 32;

  logic          clk;
  logic          rst;
  logic          cfg_wrt;
  logic [1:0]    cfg_addr;
  logic [15:0]   cfg_data;
  logic [TW-1:0] timeout_lim;
  logic          arm;
  logic          abort;
  logic          trigger0;
  logic          trigger1;
  logic [15:0]   pulse_delay;
  logic          trig_enable;
  logic [47:0]   trig_level_arr;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic [15:0]   delay_out;
  logic [15:0]   shot_cnt;
  logic [2:0]    state_dbg;

  trigger_arm_ctrl #(
    .FLUSH_CYCLES  (FC),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_wrt        (cfg_wrt),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .timeout_lim    (timeout_lim),
    .arm            (arm),
    .abort          (abort),
    .trigger0       (trigger0),
    .trigger1       (trigger1),
    .pulse_delay    (pulse_delay),
    .trig_enable    (trig_enable),
    .trig_level_arr (trig_level_arr),
    .busy           (busy),
    .done           (done),
    .timed_out      (timed_out),
    .delay_out      (delay_out),
    .shot_cnt       (shot_cnt),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #4 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: {delay_out, shot_cnt} expected at each done pulse.
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [15:0] exp_cnt;
  logic [15:0] exp_delay;
  logic [47:0] exp_arr;

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("done_result", 64'({delay_out, shot_cnt}), 64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arm from IDLE and walk through the flush window.
  task automatic arm_flush();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_busy", 64'(busy), 64'(1));
    check("arm_en_low", 64'(trig_enable), 64'(0));
    repeat (FC - 1) begin
      step();
      check("flush_en_low", 64'(trig_enable), 64'(0));
    end
    step();
    check("armed_en_high", 64'(trig_enable), 64'(1));
  endtask

  // From ARMED: trigger0 rise, trigger1 rise with delay d, trigger1 fall.
  task automatic finish_shot(input logic [15:0] d);
    trigger0 = 1'b1;
    step();
    trigger1    = 1'b1;
    pulse_delay = d;
    step();
    check("delay_capture", 64'(delay_out), 64'(d));
    pulse_delay = ~d;
    trigger1    = 1'b0;
    exp_cnt     = exp_cnt + 16'd1;
    exp_delay   = d;
    exp_q.push_back({d, exp_cnt});
    step();
    check("done_pulse", 64'(done), 64'(1));
    check("done_en_low", 64'(trig_enable), 64'(0));
    check("done_shot_cnt", 64'(shot_cnt), 64'(exp_cnt));
    trigger0 = 1'b0;
    step();
    check("post_done_low", 64'(done), 64'(0));
    check("post_done_idle", 64'(busy), 64'(0));
  endtask

  typedef struct packed {
    logic        wrt;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [47:0] exp_arr;
  } cfg_vec_t;

  cfg_vec_t vecs[6];

  initial begin
    vecs[0] = '{wrt: 1'b1, addr: 2'd1, data: 16'h0100, exp_arr: 48'h0000_0000_0100};
    vecs[1] = '{wrt: 1'b1, addr: 2'd2, data: 16'hFF00, exp_arr: 48'h0000_FF00_0100};
    vecs[2] = '{wrt: 1'b1, addr: 2'd3, data: 16'h0200, exp_arr: 48'h0200_FF00_0100};
    vecs[3] = '{wrt: 1'b1, addr: 2'd0, data: 16'hDEAD, exp_arr: 48'h0200_FF00_0100};
    vecs[4] = '{wrt: 1'b0, addr: 2'd1, data: 16'h1234, exp_arr: 48'h0200_FF00_0100};
    vecs[5] = '{wrt: 1'b1, addr: 2'd1, data: 16'h0100, exp_arr: 48'h0200_FF00_0100};

    rst = 1'b1; cfg_wrt = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h0;
    timeout_lim = '0; arm = 1'b0; abort = 1'b0;
    trigger0 = 1'b0; trigger1 = 1'b0; pulse_delay = 16'h0;
    exp_cnt = 16'h0; exp_delay = 16'hFFFF;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_en", 64'(trig_enable), 64'(0));
    check("rst_arr", 64'(trig_level_arr), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_timed_out", 64'(timed_out), 64'(0));
    check("rst_delay_out", 64'(delay_out), 64'(16'hFFFF));
    check("rst_shot_cnt", 64'(shot_cnt), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Level write table in IDLE
    for (int i = 0; i < 6; i++) begin
      cfg_wrt  = vecs[i].wrt;
      cfg_addr = vecs[i].addr;
      cfg_data = vecs[i].data;
      step();
      cfg_wrt = 1'b0;
      check("cfg_table", 64'(trig_level_arr), 64'(vecs[i].exp_arr));
    end

    // Arm with a same-cycle write to level_c, then writes while busy are dropped
    exp_arr  = 48'h0300_FF00_0100;
    cfg_wrt  = 1'b1; cfg_addr = 2'd3; cfg_data = 16'h0300; arm = 1'b1;
    step();
    cfg_wrt = 1'b0; arm = 1'b0;
    check("arm_cfg_same_cycle", 64'(trig_level_arr), 64'(exp_arr));
    check("arm_en_low", 64'(trig_enable), 64'(0));
    for (int i = 0; i < FC - 1; i++) begin
      cfg_wrt  = 1'b1;
      cfg_addr = 2'(i + 1);
      cfg_data = 16'hA5A5 ^ 16'(i);
      step();
      check("busy_write_dropped", 64'(trig_level_arr), 64'(exp_arr));
      check("flush_en_low", 64'(trig_enable), 64'(0));
    end
    cfg_wrt = 1'b0;
    step();
    check("armed_en_high", 64'(trig_enable), 64'(1));
    finish_shot(16'h0123);
    check("shot1_delay", 64'(delay_out), 64'(16'h0123));
    check("shot1_cnt", 64'(shot_cnt), 64'(1));

    // Random shots
    for (int i = 0; i < 3; i++) begin
      arm_flush();
      finish_shot(16'($urandom_range(0, 16'hFFFF)));
    end

    // Timeout: fires exactly 100 counted cycles after ARMED entry
    timeout_lim = 100;
    arm_flush();
    repeat (99) step();
    check("to_not_yet", 64'(timed_out), 64'(0));
    check("to_not_yet_en", 64'(trig_enable), 64'(1));
    step();
    check("to_hit", 64'(timed_out), 64'(1));
    check("to_hit_en", 64'(trig_enable), 64'(0));
    check("to_state_busy", 64'(busy), 64'(1));
    step();
    check("to_idle", 64'(busy), 64'(0));
    repeat (5) step();
    check("to_sticky", 64'(timed_out), 64'(1));
    check("to_no_count", 64'(shot_cnt), 64'(exp_cnt));
    check("to_no_capture", 64'(delay_out), 64'(exp_delay));
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("to_cleared_by_arm", 64'(timed_out), 64'(0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_flush", 64'(busy), 64'(0));
    timeout_lim = '0;

    // Abort in WAIT_T1
    arm_flush();
    trigger0 = 1'b1;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    trigger0 = 1'b0;
    check("abort_idle", 64'(busy), 64'(0));
    check("abort_en", 64'(trig_enable), 64'(0));
    check("abort_cnt", 64'(shot_cnt), 64'(exp_cnt));
    check("abort_delay", 64'(delay_out), 64'(exp_delay));

    // arm + abort together in IDLE: stays IDLE
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_idle", 64'(busy), 64'(0));
    check("arm_abort_en", 64'(trig_enable), 64'(0));

    // Simultaneous rise in ARMED, then trigger1 fall on the timeout edge
    timeout_lim = 10;
    arm_flush();
    trigger0 = 1'b1; trigger1 = 1'b1; pulse_delay = 16'h0456;
    step();
    pulse_delay = 16'h0;
    check("dual_rise_capture", 64'(delay_out), 64'(16'h0456));
    repeat (8) step();
    check("dual_delay_busy", 64'(busy), 64'(1));
    check("dual_delay_no_to", 64'(timed_out), 64'(0));
    trigger1  = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    exp_delay = 16'h0456;
    exp_q.push_back({16'h0456, exp_cnt});
    step();
    check("event_beats_timeout", 64'(timed_out), 64'(0));
    check("event_done", 64'(done), 64'(1));
    trigger0 = 1'b0;
    step();
    check("event_idle", 64'(busy), 64'(0));
    check("event_to_still_clear", 64'(timed_out), 64'(0));
    timeout_lim = '0;

    // Asynchronous reset in DELAY
    arm_flush();
    trigger0 = 1'b1; trigger1 = 1'b1; pulse_delay = 16'h0789;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_en", 64'(trig_enable), 64'(0));
    check("arst_arr", 64'(trig_level_arr), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_timed_out", 64'(timed_out), 64'(0));
    check("arst_delay_out", 64'(delay_out), 64'(16'hFFFF));
    check("arst_shot_cnt", 64'(shot_cnt), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    trigger0 = 1'b0; trigger1 = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'h0; exp_delay = 16'hFFFF;
    step();

    // shot_cnt wrap 0xFFFF -> 0
    force dut.shot_cnt = 16'hFFFF;
    #1;
    release dut.shot_cnt;
    exp_cnt = 16'hFFFF;
    step();
    check("wrap_preload", 64'(shot_cnt), 64'(16'hFFFF));
    arm_flush();
    finish_shot(16'h0BEE);
    check("wrap_zero", 64'(shot_cnt), 64'(0));

    repeat (2) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
